noc_intr_pkt_rx: RTL and testbench
==================================

// Module: noc_intr_pkt_rx
// PURPOSE
//  Off-chip-clock consumer of the fake IOB NoC flit stream. Parses 2-flit interrupt packets
//  (header + one payload flit), extracts destination tile and interrupt fields, and queues them
//  in a small FIFO for the interrupt injector. Non-interrupt or malformed packets are drained and counted.
// PARAMETERS
//  FIFO_DEPTH   4    decoded-interrupt FIFO entries (power of 2, >=2)
//  X_TILES      4    tiles in X; used only with INTR_RX_DEST_FILTER_EN
//  Y_TILES      4    tiles in Y; used only with INTR_RX_DEST_FILTER_EN
// PORTS
//  clk            in   1                    off-chip clock (same domain as fake IOB read port)
//  rst_n          in   1                    reset, synchronous, active-low
//  noc_in_val     in   1                    flit valid
//  noc_in_rdy     out  1                    flit accepted when val&&rdy
//  noc_in_data    in   `NOC_DATA_WIDTH      flit
//  intr_val       out  1                    FIFO head valid
//  intr_rdy       in   1                    consumer pops head when val&&rdy
//  intr_dst_x     out  `NOC_X_WIDTH         header `MSG_DST_X
//  intr_dst_y     out  `NOC_Y_WIDTH         header `MSG_DST_Y
//  intr_vec       out  9                    payload flit [8:0]
//  intr_hi        out  48                   payload flit [63:16]
//  drop_cnt       out  16                   packets dropped, saturating
//  err_len        out  1                    sticky: interrupt header with `MSG_LENGTH != 1 seen
// BEHAVIOUR
//  - Reset: FSM=HDR, FIFO empty, intr_val=0, drop_cnt=0, err_len=0, flit counter=0; outputs
//    intr_dst_*/intr_vec/intr_hi=0 when FIFO empty.
//  - FSM states HDR, PAYLOAD, DRAIN; all transitions on accepted flits only.
//  - HDR: noc_in_rdy=1. On accept: latch dst x/y, len=`MSG_LENGTH.
//      type==`MSG_TYPE_INTERRUPT && len==1 -> PAYLOAD.
//      type==INTERRUPT && len!=1 -> err_len<=1, drop_cnt++, len==0 ? stay HDR : DRAIN(len).
//      other type: drop_cnt++, len==0 ? HDR : DRAIN(len).
//  - PAYLOAD: noc_in_rdy = !fifo_full. On accept push {dst_x,dst_y,flit[8:0],flit[63:16]}; -> HDR.
//    Flit [15:9] ignored.
//  - DRAIN: noc_in_rdy=1; counter loaded with len, decrements per accepted flit; at 1 -> HDR.
//  - Header accept never blocks; only payload stalls (backpressure on full FIFO).
//  - FIFO: registered, head visible same cycle as intr_val. Simultaneous push and pop when full is
//    illegal by construction (rdy low when full); simultaneous push/pop at other occupancy keeps
//    count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - Latency: payload accept at cycle N -> intr_val=1 at N+1 (FIFO previously empty).
//  - drop_cnt saturates at 16'hFFFF; err_len cleared only by reset.
//  - Reset mid-packet: partial packet discarded; next accepted flit after reset parsed as header.
// CONFIGURATION
//  INTR_RX_DEST_FILTER_EN defined: interrupt header with dst_x>=X_TILES or dst_y>=Y_TILES is
//    treated as drop (drop_cnt++, DRAIN its len flits), never enqueued.
//  Not defined: destination fields passed through unchecked; X_TILES/Y_TILES unused.
// STRUCTURE
//  - Shared package/header: FSM state encoding, intr FIFO entry struct width
//    (`NOC_X_WIDTH+`NOC_Y_WIDTH+9+48), field slice macros for payload flit.
//  - One sub-module: intr_rx_fifo (param depth/width, push/pop/full/empty, registered storage).
//  - Header field decode uses existing `MSG_* macros from define.tmp.h.
// TESTING
//  1 Hdr type INTERRUPT len=1 dst(2,1), payload 64'h0000_ABCD_EF01_0105 -> next cycle intr_val=1,
//    dst(2,1), intr_vec=9'h105, intr_hi=48'h0000ABCDEF01.
//  2 intr_rdy=0, send 5 interrupt packets, FIFO_DEPTH=4 -> 5th payload stalls (noc_in_rdy=0),
//    raise intr_rdy -> 5 pops in order, no loss.
//  3 Non-interrupt hdr len=3 + 3 flits, then valid interrupt -> drop_cnt=1, only interrupt enqueued.
//  4 INTERRUPT hdr len=0, then interrupt len=2 + 2 flits -> err_len=1, drop_cnt=2, FIFO empty, FSM HDR.
//  5 rst_n low for 1 cycle between hdr and payload -> FIFO empty, payload flit parsed as header.
//  6 FILTER_EN, X_TILES=4: dst_x=5 len=1 -> drop_cnt=1, no intr_val; without macro -> enqueued.

Source files
------------

// File: rtl/noc_intr_pkt_rx_pkg.sv
// Shared definitions for the NoC interrupt packet receiver.
//  - NoC header field macros (used only where the codebase header has not
//    already provided them).
//  - Payload flit slice macros for the interrupt vector and high field.
//  - FSM state encoding and the decoded-interrupt FIFO entry layout.
// Optional feature macro (consumed in noc_intr_pkt_rx.sv): INTR_RX_DEST_FILTER_EN.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef NOC_X_WIDTH
`define NOC_X_WIDTH 8
`endif
`ifndef NOC_Y_WIDTH
`define NOC_Y_WIDTH 8
`endif
`ifndef MSG_DST_X
`define MSG_DST_X 49:42
`endif
`ifndef MSG_DST_Y
`define MSG_DST_Y 41:34
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif
`ifndef MSG_TYPE
`define MSG_TYPE 21:14
`endif
`ifndef MSG_TYPE_INTERRUPT
`define MSG_TYPE_INTERRUPT 8'd33
`endif

// Payload flit slices; bits [15:9] carry nothing of interest.
`define INTR_PAYLOAD_VEC 8:0
`define INTR_PAYLOAD_HI  63:16

package noc_intr_pkt_rx_pkg;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } rx_state_e;

    localparam int INTR_VEC_W   = 9;
    localparam int INTR_HI_W    = 48;
    localparam int INTR_ENTRY_W = `NOC_X_WIDTH + `NOC_Y_WIDTH + INTR_VEC_W + INTR_HI_W;

    typedef struct packed {
        logic [`NOC_X_WIDTH-1:0] dst_x;
        logic [`NOC_Y_WIDTH-1:0] dst_y;
        logic [INTR_VEC_W-1:0]   vec;
        logic [INTR_HI_W-1:0]    hi;
    } intr_entry_t;

endpackage

// File: rtl/noc_intr_pkt_rx_fifo.sv
// intr_rx_fifo: small synchronous FIFO for decoded interrupts.
// Ports:
//  clk, rst_n       clock, synchronous active-low reset
//  push, push_data  write request / data (ignored when full)
//  pop              read request (ignored when empty)
//  pop_data         head entry, valid whenever !empty
//  full, empty      occupancy flags
// DEPTH must be a power of two so pointers wrap naturally.

module intr_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/noc_intr_pkt_rx.sv
// noc_intr_pkt_rx: parses 2-flit interrupt packets from the NoC flit stream,
// queues {dst_x, dst_y, vec, hi} for the interrupt injector, drains and counts
// every other packet.
// Ports:
//  clk, rst_n                    clock, synchronous active-low reset
//  noc_in_val/rdy/data           incoming flit handshake
//  intr_val/rdy                  decoded interrupt handshake (FIFO head)
//  intr_dst_x/y, intr_vec/hi     head fields, zero when FIFO empty
//  drop_cnt                      saturating dropped-packet count
//  err_len                       sticky: interrupt header with length != 1
// Optional: INTR_RX_DEST_FILTER_EN drops interrupts whose destination lies
// outside the X_TILES x Y_TILES mesh.

import noc_intr_pkt_rx_pkg::*;

module noc_intr_pkt_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int X_TILES    = 4,
    parameter int Y_TILES    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       noc_in_val,
    output logic                       noc_in_rdy,
    input  logic [`NOC_DATA_WIDTH-1:0] noc_in_data,
    output logic                       intr_val,
    input  logic                       intr_rdy,
    output logic [`NOC_X_WIDTH-1:0]    intr_dst_x,
    output logic [`NOC_Y_WIDTH-1:0]    intr_dst_y,
    output logic [8:0]                 intr_vec,
    output logic [47:0]                intr_hi,
    output logic [15:0]                drop_cnt,
    output logic                       err_len
);
    rx_state_e                    state_q, state_d;
    logic [`MSG_LENGTH_WIDTH-1:0] cnt_q, cnt_d;
    logic [`NOC_X_WIDTH-1:0]      dst_x_q, dst_x_d;
    logic [`NOC_Y_WIDTH-1:0]      dst_y_q, dst_y_d;
    logic [15:0]                  drop_cnt_q, drop_cnt_d;
    logic                         err_len_q, err_len_d;

    logic                         accept, drop_inc, push, fifo_full, fifo_empty;
    logic                         is_intr, dst_bad;
    logic [`NOC_X_WIDTH-1:0]      hdr_x;
    logic [`NOC_Y_WIDTH-1:0]      hdr_y;
    logic [`MSG_LENGTH_WIDTH-1:0] hdr_len;
    intr_entry_t                  push_entry, head_entry;

    assign hdr_x   = noc_in_data[`MSG_DST_X];
    assign hdr_y   = noc_in_data[`MSG_DST_Y];
    assign hdr_len = noc_in_data[`MSG_LENGTH];
    assign is_intr = (noc_in_data[`MSG_TYPE] == `MSG_TYPE_INTERRUPT);
    assign accept  = noc_in_val && noc_in_rdy;

`ifdef INTR_RX_DEST_FILTER_EN
    assign dst_bad = (int'(hdr_x) >= X_TILES) || (int'(hdr_y) >= Y_TILES);
`else
    localparam int unused_tiles = X_TILES + Y_TILES;
    assign dst_bad = 1'b0;
`endif

    // Header bits outside the decoded fields are intentionally ignored.
    logic unused_flit_bits;
    assign unused_flit_bits = ^noc_in_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dst_x_d    = dst_x_q;
        dst_y_d    = dst_y_q;
        err_len_d  = err_len_q;
        drop_inc   = 1'b0;
        push       = 1'b0;
        noc_in_rdy = 1'b1;
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    dst_x_d = hdr_x;
                    dst_y_d = hdr_y;
                    if (is_intr && hdr_len == `MSG_LENGTH_WIDTH'(1) && !dst_bad) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        drop_inc = 1'b1;
                        if (is_intr && hdr_len != `MSG_LENGTH_WIDTH'(1)) err_len_d = 1'b1;
                        if (hdr_len == '0) begin
                            state_d = ST_HDR;
                        end else begin
                            state_d = ST_DRAIN;
                            cnt_d   = hdr_len;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                // Only the payload flit can stall, and only on a full FIFO.
                noc_in_rdy = !fifo_full;
                if (accept) begin
                    push    = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    if (cnt_q == `MSG_LENGTH_WIDTH'(1)) state_d = ST_HDR;
                    else                               cnt_d   = cnt_q - `MSG_LENGTH_WIDTH'(1);
                end
            end
            default: state_d = ST_HDR;
        endcase
        drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_HDR;
            cnt_q      <= '0;
            dst_x_q    <= '0;
            dst_y_q    <= '0;
            drop_cnt_q <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dst_x_q    <= dst_x_d;
            dst_y_q    <= dst_y_d;
            drop_cnt_q <= drop_cnt_d;
            err_len_q  <= err_len_d;
        end
    end

    assign push_entry.dst_x = dst_x_q;
    assign push_entry.dst_y = dst_y_q;
    assign push_entry.vec   = noc_in_data[`INTR_PAYLOAD_VEC];
    assign push_entry.hi    = noc_in_data[`INTR_PAYLOAD_HI];

    intr_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INTR_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (intr_rdy),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign intr_val   = !fifo_empty;
    assign intr_dst_x = fifo_empty ? '0 : head_entry.dst_x;
    assign intr_dst_y = fifo_empty ? '0 : head_entry.dst_y;
    assign intr_vec   = fifo_empty ? '0 : head_entry.vec;
    assign intr_hi    = fifo_empty ? '0 : head_entry.hi;
    assign drop_cnt   = drop_cnt_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_noc_intr_pkt_rx.sv
// Directed bench for noc_intr_pkt_rx: a table of interrupt packets with
// hand-computed decoded fields, plus sequences for backpressure, drains,
// length errors, mid-packet reset and destination filtering.

module tb_noc_intr_pkt_rx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        noc_in_val;
    logic        noc_in_rdy;
    logic [63:0] noc_in_data;
    logic        intr_val;
    logic        intr_rdy;
    logic [7:0]  intr_dst_x;
    logic [7:0]  intr_dst_y;
    logic [8:0]  intr_vec;
    logic [47:0] intr_hi;
    logic [15:0] drop_cnt;
    logic        err_len;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    noc_intr_pkt_rx dut (
        .clk(clk), .rst_n(rst_n),
        .noc_in_val(noc_in_val), .noc_in_rdy(noc_in_rdy), .noc_in_data(noc_in_data),
        .intr_val(intr_val), .intr_rdy(intr_rdy),
        .intr_dst_x(intr_dst_x), .intr_dst_y(intr_dst_y),
        .intr_vec(intr_vec), .intr_hi(intr_hi),
        .drop_cnt(drop_cnt), .err_len(err_len)
    );

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [63:0] payload;
        logic [8:0]  vec;
        logic [47:0] hi;
    } vec_t;

    vec_t tbl [5];

    localparam logic [7:0] T_INTR  = 8'd33;
    localparam logic [7:0] T_OTHER = 8'd5;

    // Header layout: dst_x [49:42], dst_y [41:34], length [29:22], type [21:14].
    function automatic logic [63:0] hdr(input logic [7:0] t, input logic [7:0] len,
                                        input logic [7:0] x, input logic [7:0] y);
        logic [63:0] h;
        h = '0;
        h[49:42] = x;
        h[41:34] = y;
        h[29:22] = len;
        h[21:14] = t;
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, got);
        end
    endtask

    task automatic send(input logic [63:0] d, output bit ok);
        ok = 1'b0;
        noc_in_val  = 1'b1;
        noc_in_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (noc_in_rdy) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        noc_in_val = 1'b0;
    endtask

    task automatic send_chk(input string name, input logic [63:0] d);
        bit ok;
        send(d, ok);
        chk({name, "_accepted"}, 64'(ok), 64'd1);
    endtask

    task automatic pop_chk(input string name, input logic [7:0] x, input logic [7:0] y,
                           input logic [8:0] v, input logic [47:0] h);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (intr_val) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_val"}, 64'(seen), 64'd1);
        chk({name, "_head"}, {intr_dst_x, intr_dst_y, intr_vec, 39'd0},
            {x, y, v, 39'd0});
        chk({name, "_hi"}, 64'(intr_hi), 64'(h));
        intr_rdy = 1'b1;
        @(posedge clk);
        #1;
        intr_rdy = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_drop;

        tbl[0] = '{8'd2, 8'd1, 64'h0000_ABCD_EF01_0105, 9'h105, 48'h0000_ABCD_EF01};
        tbl[1] = '{8'd3, 8'd0, 64'hFFFF_FFFF_FFFF_FE00, 9'h000, 48'hFFFF_FFFF_FFFF};
        tbl[2] = '{8'd0, 8'd3, 64'h1234_5678_9ABC_81FF, 9'h1FF, 48'h1234_5678_9ABC};
        tbl[3] = '{8'd1, 8'd2, 64'h8000_0000_0001_7E5A, 9'h05A, 48'h8000_0000_0001};
        tbl[4] = '{8'd3, 8'd3, 64'h0F0F_F0F0_A5A5_0100, 9'h100, 48'h0F0F_F0F0_A5A5};

        rst_n = 1'b0; noc_in_val = 1'b0; noc_in_data = '0; intr_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset_intr_val", 64'(intr_val), 64'd0);
        chk("reset_outputs", {intr_dst_x, intr_dst_y, intr_vec, 39'd0}, 64'd0);
        chk("reset_hi", 64'(intr_hi), 64'd0);
        chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("reset_err_len", 64'(err_len), 64'd0);
        chk("reset_rdy", 64'(noc_in_rdy), 64'd1);
        exp_drop = 16'd0;

        // Single packets: one-cycle latency from payload accept to intr_val.
        for (int i = 0; i < 5; i++) begin
            send_chk($sformatf("pkt%0d_hdr", i), hdr(T_INTR, 8'd1, tbl[i].x, tbl[i].y));
            chk($sformatf("pkt%0d_val_before", i), 64'(intr_val), 64'd0);
            send_chk($sformatf("pkt%0d_pay", i), tbl[i].payload);
            chk($sformatf("pkt%0d_latency", i), 64'(intr_val), 64'd1);
            pop_chk($sformatf("pkt%0d_pop", i), tbl[i].x, tbl[i].y, tbl[i].vec, tbl[i].hi);
            chk($sformatf("pkt%0d_empty", i), 64'(intr_val), 64'd0);
        end

        // Backpressure: four fill the FIFO, fifth payload stalls.
        for (int i = 0; i < 4; i++) begin
            send_chk($sformatf("fill%0d_hdr", i), hdr(T_INTR, 8'd1, tbl[i].x, tbl[i].y));
            send_chk($sformatf("fill%0d_pay", i), tbl[i].payload);
        end
        send_chk("fill4_hdr", hdr(T_INTR, 8'd1, tbl[4].x, tbl[4].y));
        noc_in_val  = 1'b1;
        noc_in_data = tbl[4].payload;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_rdy", i), 64'(noc_in_rdy), 64'd0);
        end
        pop_chk("fill_pop0", tbl[0].x, tbl[0].y, tbl[0].vec, tbl[0].hi);
        send_chk("fill4_pay", tbl[4].payload);
        for (int i = 1; i < 5; i++)
            pop_chk($sformatf("fill_pop%0d", i), tbl[i].x, tbl[i].y, tbl[i].vec, tbl[i].hi);
        chk("fill_empty", 64'(intr_val), 64'd0);
        chk("fill_no_drop", 64'(drop_cnt), 64'(exp_drop));

        // Non-interrupt packet with 3 body flits that look like interrupt headers.
        send_chk("other_hdr", hdr(T_OTHER, 8'd3, 8'd1, 8'd1));
        for (int i = 0; i < 3; i++)
            send_chk($sformatf("other_body%0d", i), hdr(T_INTR, 8'd1, 8'd0, 8'd0));
        exp_drop++;
        chk("other_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        chk("other_no_intr", 64'(intr_val), 64'd0);
        chk("other_err_len", 64'(err_len), 64'd0);
        send_chk("after_other_hdr", hdr(T_INTR, 8'd1, tbl[2].x, tbl[2].y));
        send_chk("after_other_pay", tbl[2].payload);
        pop_chk("after_other_pop", tbl[2].x, tbl[2].y, tbl[2].vec, tbl[2].hi);
        chk("after_other_empty", 64'(intr_val), 64'd0);

        // Interrupt length errors: len=0 then len=2 with two body flits.
        send_chk("len0_hdr", hdr(T_INTR, 8'd0, 8'd1, 8'd1));
        exp_drop++;
        chk("len0_err_len", 64'(err_len), 64'd1);
        send_chk("len2_hdr", hdr(T_INTR, 8'd2, 8'd1, 8'd1));
        send_chk("len2_body0", tbl[0].payload);
        send_chk("len2_body1", tbl[1].payload);
        exp_drop++;
        chk("len_err_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        chk("len_err_empty", 64'(intr_val), 64'd0);
        chk("len_err_sticky", 64'(err_len), 64'd1);
        send_chk("after_len_hdr", hdr(T_INTR, 8'd1, tbl[3].x, tbl[3].y));
        send_chk("after_len_pay", tbl[3].payload);
        pop_chk("after_len_pop", tbl[3].x, tbl[3].y, tbl[3].vec, tbl[3].hi);

        // Reset between header and payload: payload flit becomes a header.
        send_chk("rst_hdr", hdr(T_INTR, 8'd1, 8'd2, 8'd2));
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_empty", 64'(intr_val), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        exp_drop = 16'd0;
        send_chk("rst_pay_as_hdr", hdr(T_OTHER, 8'd0, 8'd1, 8'd1) | 64'h105);
        exp_drop++;
        chk("rst_pay_drop", 64'(drop_cnt), 64'(exp_drop));
        chk("rst_pay_no_intr", 64'(intr_val), 64'd0);

        // Destination outside the 4x4 mesh.
        send_chk("far_hdr", hdr(T_INTR, 8'd1, 8'd5, 8'd1));
        send_chk("far_pay", tbl[0].payload);
`ifdef INTR_RX_DEST_FILTER_EN
        exp_drop++;
        chk("far_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        chk("far_no_intr", 64'(intr_val), 64'd0);
        send_chk("far_y_hdr", hdr(T_INTR, 8'd1, 8'd0, 8'd4));
        send_chk("far_y_pay", tbl[1].payload);
        exp_drop++;
        chk("far_y_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        chk("far_y_no_intr", 64'(intr_val), 64'd0);
`else
        chk("far_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        pop_chk("far_pop", 8'd5, 8'd1, tbl[0].vec, tbl[0].hi);
`endif
        chk("final_empty", 64'(intr_val), 64'd0);
        chk("final_state_hdr", 64'(noc_in_rdy), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
